// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: filtered clock, 11-bit frame FSM, E0/F0 prefix folding.
// Define PS2_PARITY_CHECK_EN to discard frames with bad odd parity.
module ps2_scan_decoder #(
   parameter int FILTER_CYCLES  = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       makeBreak,
   output logic       extended,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int FW  = $clog2(FILTER_CYCLES + 1);
   localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t         state;
   logic [1:0]     clk_sync;
   logic [1:0]     data_sync;
   logic           filt_clk;
   logic [FW-1:0]  fcnt;
   logic           sample;
   logic           sample_bit;
   logic [2:0]     bcnt;
   logic [7:0]     shreg;
   logic [WDW-1:0] wd;
   logic           ext_pend;
   logic           break_pend;
   logic           par_ok;

`ifdef PS2_PARITY_CHECK_EN
   logic par;
   assign par_ok = ^{shreg, par};
`else
   assign par_ok = 1'b1;
`endif

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // Level changes only after FILTER_CYCLES consecutive differing samples
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         filt_clk   <= 1'b1;
         fcnt       <= '0;
         sample     <= 1'b0;
         sample_bit <= 1'b1;
      end else begin
         sample <= 1'b0;
         if (clk_sync[1] == filt_clk) begin
            fcnt <= '0;
         end else if (fcnt == FW'(FILTER_CYCLES - 1)) begin
            filt_clk <= clk_sync[1];
            fcnt     <= '0;
            if (filt_clk) begin
               sample     <= 1'b1;
               sample_bit <= data_sync[1];
            end
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state      <= IDLE;
         bcnt       <= '0;
         shreg      <= '0;
         wd         <= '0;
         ext_pend   <= 1'b0;
         break_pend <= 1'b0;
         scan_code  <= 8'h00;
         makeBreak  <= 1'b0;
         extended   <= 1'b0;
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
         par        <= 1'b0;
`endif
      end else begin
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (sample) begin
            wd <= '0;
            unique case (state)
               IDLE: begin
                  if (!sample_bit) begin
                     state <= DATA;
                     bcnt  <= '0;
                  end
               end
               DATA: begin
                  shreg <= {sample_bit, shreg[7:1]};
                  bcnt  <= bcnt + 1'b1;
                  if (bcnt == 3'd7) state <= PARITY;
               end
               PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                  par <= sample_bit;
`endif
                  state <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (sample_bit && par_ok) begin
                     if (shreg == 8'hE0) begin
                        ext_pend <= 1'b1;
                     end else if (shreg == 8'hF0) begin
                        break_pend <= 1'b1;
                     end else begin
                        scan_code  <= shreg;
                        makeBreak  <= ~break_pend;
                        extended   <= ext_pend;
                        code_valid <= 1'b1;
                        ext_pend   <= 1'b0;
                        break_pend <= 1'b0;
                     end
                  end else begin
                     frame_err  <= 1'b1;
                     ext_pend   <= 1'b0;
                     break_pend <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state == IDLE) begin
            wd <= '0;
         end else if (wd == WDW'(TIMEOUT_CYCLES - 1)) begin
            state      <= IDLE;
            wd         <= '0;
            frame_err  <= 1'b1;
            ext_pend   <= 1'b0;
            break_pend <= 1'b0;
         end else begin
            wd <= wd + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: directed PS/2 frames plus random byte stream
// checked against an event-level model of the prefix rules.
module tb_ps2_scan_decoder;

   localparam int T    = 1000;
   localparam int HALF = 20;
`ifdef PS2_PARITY_CHECK_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       CLOCK_50 = 1'b0;
   logic       reset    = 1'b1;
   logic       ps2_clk  = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] scan_code;
   logic       makeBreak, extended, code_valid, frame_err;

   ps2_scan_decoder #(.FILTER_CYCLES(8), .TIMEOUT_CYCLES(T)) u_dut (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .scan_code (scan_code),
      .makeBreak (makeBreak),
      .extended  (extended),
      .code_valid(code_valid),
      .frame_err (frame_err)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   int checks = 0, errors = 0;
   int nv = 0, ne = 0, both = 0;
   int cyc = 0, err_cyc = 0, tlast = 0;

   logic [7:0] m_code;
   logic       m_mb, m_ext, m_ep, m_bp;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   always @(negedge CLOCK_50) begin
      if (code_valid) nv = nv + 1;
      if (frame_err) begin
         ne = ne + 1;
         err_cyc = cyc;
      end
      if (code_valid && frame_err) both = both + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_code = 8'h00; m_mb = 1'b0; m_ext = 1'b0;
      m_ep = 1'b0; m_bp = 1'b0;
   endtask

   task automatic clk_bit(input logic b);
      ps2_data = b;
      repeat (HALF) @(posedge CLOCK_50);
      ps2_clk = 1'b0;
      tlast = cyc;
      repeat (HALF) @(posedge CLOCK_50);
      ps2_clk = 1'b1;
   endtask

   task automatic frame(input string tag, input logic [7:0] b,
                        input logic par_good, input logic stop);
      int nv0, ne0, ev, ee;
      logic p;
      nv0 = nv; ne0 = ne; ev = 0; ee = 0;
      p = par_good ? ~^b : ^b;
      clk_bit(1'b0);
      for (int i = 0; i < 8; i++) clk_bit(b[i]);
      clk_bit(p);
      clk_bit(stop);
      ps2_data = 1'b1;
      repeat (3 * HALF) @(posedge CLOCK_50);
      if (stop && (par_good || !PAR_EN)) begin
         if (b == 8'hE0) m_ep = 1'b1;
         else if (b == 8'hF0) m_bp = 1'b1;
         else begin
            m_code = b; m_mb = ~m_bp; m_ext = m_ep;
            m_ep = 1'b0; m_bp = 1'b0; ev = 1;
         end
      end else begin
         m_ep = 1'b0; m_bp = 1'b0; ee = 1;
      end
      chk({tag, "/valid"}, nv - nv0, ev);
      chk({tag, "/err"}, ne - ne0, ee);
      chk({tag, "/code"}, int'(scan_code), int'(m_code));
      chk({tag, "/mb"}, int'(makeBreak), int'(m_mb));
      chk({tag, "/ext"}, int'(extended), int'(m_ext));
   endtask

   initial begin
      int nv0, ne0, lat;
      logic [7:0] b;
      int r;
      model_reset();
      repeat (5) @(posedge CLOCK_50);
      reset = 1'b0;
      repeat (5) @(posedge CLOCK_50);
      chk("rst/code", int'(scan_code), 0);
      chk("rst/mb", int'(makeBreak), 0);
      chk("rst/ext", int'(extended), 0);
      chk("rst/valid", int'(code_valid), 0);
      chk("rst/err", int'(frame_err), 0);

      frame("m75", 8'h75, 1'b1, 1'b1);
      frame("F0", 8'hF0, 1'b1, 1'b1);
      frame("b75", 8'h75, 1'b1, 1'b1);
      frame("m75b", 8'h75, 1'b1, 1'b1);
      frame("E0", 8'hE0, 1'b1, 1'b1);
      frame("e6B", 8'h6B, 1'b1, 1'b1);
      frame("m72", 8'h72, 1'b1, 1'b1);
      frame("p72", 8'h72, 1'b0, 1'b1);
      frame("stop", 8'h11, 1'b1, 1'b0);
      frame("m74a", 8'h74, 1'b1, 1'b1);

      frame("E0to", 8'hE0, 1'b1, 1'b1);
      nv0 = nv; ne0 = ne;
      clk_bit(1'b0);
      for (int i = 0; i < 4; i++) clk_bit(1'(i & 1));
      ps2_data = 1'b1;
      for (int i = 0; i < T + 200 && ne == ne0; i++) @(posedge CLOCK_50);
      repeat (2) @(posedge CLOCK_50);
      m_ep = 1'b0; m_bp = 1'b0;
      lat = err_cyc - tlast;
      chk("to/err", ne - ne0, 1);
      chk("to/valid", nv - nv0, 0);
      chk("to/lat", int'(lat >= T && lat <= T + 20), 1);
      frame("m74", 8'h74, 1'b1, 1'b1);

      nv0 = nv; ne0 = ne;
      ps2_data = 1'b0;
      repeat (5) @(posedge CLOCK_50);
      ps2_clk = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      ps2_clk = 1'b1;
      repeat (30) @(posedge CLOCK_50);
      ps2_data = 1'b1;
      repeat (20) @(posedge CLOCK_50);
      chk("gl/valid", nv - nv0, 0);
      chk("gl/err", ne - ne0, 0);
      frame("gl1C", 8'h1C, 1'b1, 1'b1);

      frame("E0rs", 8'hE0, 1'b1, 1'b1);
      nv0 = nv; ne0 = ne;
      clk_bit(1'b0);
      clk_bit(1'b1);
      clk_bit(1'b0);
      reset = 1'b1;
      repeat (5) @(posedge CLOCK_50);
      reset = 1'b0;
      model_reset();
      repeat (T + 50) @(posedge CLOCK_50);
      chk("rs/valid", nv - nv0, 0);
      chk("rs/err", ne - ne0, 0);
      chk("rs/code", int'(scan_code), 0);
      frame("rs6B", 8'h6B, 1'b1, 1'b1);

      for (int k = 0; k < 20; k++) begin
         r = int'($urandom_range(0, 9));
         if (r < 2) b = 8'hE0;
         else if (r < 4) b = 8'hF0;
         else b = 8'($urandom_range(0, 255));
         frame($sformatf("rnd%0d", k), b,
               1'($urandom_range(0, 7) != 0),
               1'($urandom_range(0, 9) != 0));
      end

      chk("both", both, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
